truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Sequencer that drives a combinational N-input truth-table gate (the `0xNN` logic modules) through every input combination. It waits a programmable settle time at each vector, samples the gate output and assembles the measured truth table in the codebase's hex-name bit order. It sits between a test/configuration host and one gate instance, and is used for self-characterisation of synthesised logic.

## Interface
Parameters:
- N_IN, 3, number of gate inputs; table width is 2**N_IN.
- SETTLE_CYCLES, 4, cycles each vector is held before sampling; legal range 0..255.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a sweep; honoured only in IDLE.
- abort  in  1  cancel a sweep in progress.
- dut_in  out  N_IN  drives gate inputs; MSB maps to in1.
- dut_out  in  1  gate output.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- table  out  2**N_IN  measured truth table.
- expected  in  2**N_IN  reference table; present only with TT_SWEEP_COMPARE_EN.
- mismatch  out  1  table differs from expected; present only with TT_SWEEP_COMPARE_EN.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - dut_in=0, busy=0.
  - start=1 -> SETTLE; clear table, vec=0, cnt=0.
- SETTLE:
  - dut_in=vec; cnt increments each cycle.
  - When cnt==SETTLE_CYCLES, go to SAMPLE.
  - SETTLE_CYCLES=0 skips SETTLE entirely: start leads directly to SAMPLE.
- SAMPLE:
  - Capture dut_out into table bit (2**N_IN-1-vec), so vector 000 lands in the MSB.
  - For the 0xF4 gate this gives table=8'hF4.
  - If vec==2**N_IN-1 -> DONE; else vec+1, cnt=0, back to SETTLE (or SAMPLE when SETTLE_CYCLES=0).
- DONE:
  - done=1, busy=0, dut_in=0; go to IDLE next cycle.
- table holds its value from DONE until the next accepted start.
- abort=1 in SETTLE or SAMPLE:
  - Go to IDLE next cycle; no done pulse.
  - No capture occurs in that cycle.
  - table keeps the partial result; partial results are not reported.
  - abort has priority over the SAMPLE capture and over the transition to DONE.
- start while busy or in DONE is ignored; start and abort together in IDLE: start wins.
- vec counter is N_IN+1 bits wide internally so the final-vector compare has no wrap ambiguity. cnt is 8 bits.

## Timing
- Reset values: dut_in=0, busy=0, done=0, table=0, mismatch=0, state=IDLE.
- Reset mid-sweep returns to these values immediately (asynchronous).
- start sampled at edge E: busy=1 from E+1.
- Each vector takes SETTLE_CYCLES+1 cycles.
- busy lasts 2**N_IN*(SETTLE_CYCLES+1) cycles; done is high in the cycle after the last SAMPLE.
- Defaults: busy = 40 cycles, done at E+41.
- dut_in changes only on entry to SETTLE or on return to IDLE, never during SAMPLE.
- A new start is accepted one cycle after done, so back-to-back sweeps have a 1-cycle IDLE gap.

## Configuration
- TT_SWEEP_COMPARE_EN defined:
  - expected port and mismatch port exist.
  - mismatch is registered and updates in the DONE cycle to (table != expected).
  - mismatch holds until the next start, which clears it.
- TT_SWEEP_COMPARE_EN undefined:
  - Neither port exists; no compare logic is built.

## Structure
- Shared package tt_sweep_pkg holds:
  - the state enum (IDLE/SETTLE/SAMPLE/DONE);
  - the settle-counter width constant (8);
  - a function mapping vector index to table bit position.
- One sub-module, tt_settle_timer: loadable down/up counter with a terminal flag, instantiated by the sequencer FSM.

## Test plan
- Gate model 0xF4, defaults, start pulse -> busy for 40 cycles, done at E+41, table=8'hF4, dut_in walks 0..7 each held 5 cycles.
- SETTLE_CYCLES=0, gate model constant 1 -> busy 8 cycles, table=8'hFF.
- abort asserted during vector 3 -> IDLE next cycle, no done, dut_in=0, busy=0; a fresh start then yields table=8'hF4.
- start asserted continuously -> sweeps repeat with exactly 1 IDLE cycle between done and the next busy.
- rst pulsed mid-sweep at vector 5 -> all outputs 0 in the same cycle; a following start completes normally.
- TT_SWEEP_COMPARE_EN, expected=8'hF4 with gate 0xF4 -> mismatch=0; expected=8'hF5 -> mismatch=1 at done, cleared on next start.

Source files
------------

// File: rtl/tt_sweep_pkg.sv
`default_nettype none
// tt_sweep_pkg: shared state encoding, counter width and table-bit mapping for the sweeper.
// Rev 1.0
package tt_sweep_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Vector 0 lands in the table MSB, matching the hex naming of the gate modules.
  function automatic int unsigned bit_pos(input int unsigned vec, input int unsigned n_in);
    return (32'd1 << n_in) - 32'd1 - vec;
  endfunction

endpackage
`default_nettype wire

// File: rtl/truth_table_sweeper_if.sv
`default_nettype none
// truth_table_sweeper_if: host-side handshake and result bus; expected/mismatch exist only
// with TT_SWEEP_COMPARE_EN. Rev 1.0
interface truth_table_sweeper_if #(
  parameter int N_IN = 3
);
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [2**N_IN-1:0] meas_table;
`ifdef TT_SWEEP_COMPARE_EN
  logic [2**N_IN-1:0] expected;
  logic              mismatch;

  modport master (output start, abort, expected, input busy, done, meas_table, mismatch);
  modport slave  (input start, abort, expected, output busy, done, meas_table, mismatch);
`else
  modport master (output start, abort, input busy, done, meas_table);
  modport slave  (input start, abort, output busy, done, meas_table);
`endif
endinterface
`default_nettype wire

// File: rtl/tt_settle_timer.sv
`default_nettype none
// tt_settle_timer: loadable up counter whose terminal flag marks the last settle cycle.
// Rev 1.0
module tt_settle_timer
  import tt_sweep_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic term
);

  // term is raised in the LIMIT-th counting cycle so that LIMIT cycles are spent counting.
  localparam logic [CNT_W-1:0] TERM_VAL = (LIMIT == 0) ? '0 : CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end

  assign term = (cnt == TERM_VAL);

endmodule
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// truth_table_sweeper: walks a gate through every input vector and assembles its truth table.
// Optional compare against a reference table: TT_SWEEP_COMPARE_EN. Rev 1.0
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_sweeper_if.slave  host,
  output logic [N_IN-1:0]       dut_in,
  input  logic                  dut_out
);

  localparam int            TW        = 2**N_IN;
  localparam logic [N_IN:0] VEC_LAST  = (N_IN+1)'(TW - 1);
  localparam bit            NO_SETTLE = (SETTLE_CYCLES == 0);

  state_t          state;
  state_t          state_nxt;
  logic [N_IN:0]   vec;
  logic [TW-1:0]   tbl;
  logic [TW-1:0]   tbl_nxt;
  logic [N_IN-1:0] pos;
  logic            settle_done;
  logic            last_vec;
  logic            accept;
  logic            capture;

  assign last_vec = (vec == VEC_LAST);
  assign accept   = (state == IDLE) && host.start;
  assign capture  = (state == SAMPLE) && !host.abort;
  assign pos      = N_IN'(bit_pos(32'(vec), N_IN));

  tt_settle_timer #(
    .LIMIT (SETTLE_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (state != SETTLE),
    .en   (state == SETTLE),
    .term (settle_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (host.start) state_nxt = NO_SETTLE ? SAMPLE : SETTLE;
      SETTLE:  if (host.abort) state_nxt = IDLE;
               else if (settle_done) state_nxt = SAMPLE;
      SAMPLE:  if (host.abort) state_nxt = IDLE;
               else if (last_vec) state_nxt = DONE;
               else state_nxt = NO_SETTLE ? SAMPLE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    host.busy = (state == SETTLE) || (state == SAMPLE);
    host.done = (state == DONE);
    dut_in    = host.busy ? vec[N_IN-1:0] : '0;
  end

  // Current sample merged into the table; also feeds the compare so mismatch is valid in DONE.
  always_comb begin
    tbl_nxt      = tbl;
    tbl_nxt[pos] = dut_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec <= '0;
      tbl <= '0;
    end else if (accept) begin
      vec <= '0;
      tbl <= '0;
    end else if (capture) begin
      tbl <= tbl_nxt;
      if (!last_vec) vec <= vec + 1'b1;
    end
  end

  assign host.meas_table = tbl;

`ifdef TT_SWEEP_COMPARE_EN
  logic mismatch_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       mismatch_q <= 1'b0;
    else if (accept)               mismatch_q <= 1'b0;
    else if (capture && last_vec)  mismatch_q <= (tbl_nxt != host.expected);
  end

  assign host.mismatch = mismatch_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`timescale 1ns/1ps
`default_nettype none
// tb_truth_table_sweeper: scoreboard bench for two sweepers (settle 4 on a 0xF4 gate, settle 0 on constant 1).
// Rev 1.0
module tb_truth_table_sweeper;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(N)) hif  ();
  truth_table_sweeper_if #(.N_IN(N)) hif0 ();

  logic [N-1:0] dut_in;
  logic [N-1:0] dut_in0;
  logic         dut_out;
  logic         dut_out0;
  logic [7:0]   gate_tt;
  logic [2:0]   gidx;

  assign gate_tt  = 8'hF4;
  assign gidx     = 3'd7 - dut_in;
  assign dut_out  = gate_tt[gidx];
  assign dut_out0 = 1'b1;

  truth_table_sweeper #(.N_IN(N), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .host(hif), .dut_in(dut_in), .dut_out(dut_out)
  );

  truth_table_sweeper #(.N_IN(N), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .host(hif0), .dut_in(dut_in0), .dut_out(dut_out0)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] sb_q[$];

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic start_pulse();
    @(negedge clk); hif.start = 1'b1;
    @(negedge clk); hif.start = 1'b0;
  endtask

  task automatic start_pulse0();
    @(negedge clk); hif0.start = 1'b1;
    @(negedge clk); hif0.start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    for (int i = 0; i < 200 && !hif.done; i++) @(negedge clk);
    ok = hif.done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hif.start = 1'b0; hif.abort = 1'b0; hif0.start = 1'b0; hif0.abort = 1'b0;
`ifdef TT_SWEEP_COMPARE_EN
    hif.expected = 8'hF4; hif0.expected = 8'hFF;
`endif
    repeat (3) @(negedge clk);
    n_vec++; if ({hif.busy, hif.done} !== 2'b00) begin n_err++; $display("FAIL reset_busy_done: got %b, want 00", {hif.busy, hif.done}); end
    n_vec++; if (hif.meas_table !== 8'h00) begin n_err++; $display("FAIL reset_table: got %h, want 00", hif.meas_table); end
    n_vec++; if (dut_in !== 3'd0) begin n_err++; $display("FAIL reset_dut_in: got %0d, want 0", dut_in); end
    n_vec++; if ({hif0.busy, hif0.done, hif0.meas_table, dut_in0} !== 13'd0) begin n_err++; $display("FAIL reset_dut0: got %h, want 0", {hif0.busy, hif0.done, hif0.meas_table, dut_in0}); end
`ifdef TT_SWEEP_COMPARE_EN
    n_vec++; if (hif.mismatch !== 1'b0) begin n_err++; $display("FAIL reset_mismatch: got %b, want 0", hif.mismatch); end
`endif
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sweep_f4();
    int busy_cnt = 0;
    int walk_err = 0;
    logic [7:0] exp_t;
    start_pulse();
    sb_q.push_back(8'hF4);
    while (hif.busy && busy_cnt < 200) begin
      if (dut_in !== 3'(busy_cnt / 5)) walk_err++;
      busy_cnt++;
      @(negedge clk);
    end
    n_vec++; if (busy_cnt != 40) begin n_err++; $display("FAIL f4_busy_len: got %0d, want 40", busy_cnt); end
    n_vec++; if (walk_err != 0) begin n_err++; $display("FAIL f4_dut_in_walk: got %0d bad cycles, want 0", walk_err); end
    n_vec++; if (hif.done !== 1'b1) begin n_err++; $display("FAIL f4_done_at_e41: got %b, want 1", hif.done); end
`ifdef TT_SWEEP_COMPARE_EN
    n_vec++; if (hif.mismatch !== 1'b0) begin n_err++; $display("FAIL f4_mismatch: got %b, want 0", hif.mismatch); end
`endif
    exp_t = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
    n_vec++; if (hif.meas_table !== exp_t) begin n_err++; $display("FAIL f4_table: got %h, want %h", hif.meas_table, exp_t); end
    @(negedge clk);
    n_vec++; if ({hif.busy, hif.done} !== 2'b00) begin n_err++; $display("FAIL f4_done_pulse: got %b, want 00", {hif.busy, hif.done}); end
    repeat (3) @(negedge clk);
    n_vec++; if (hif.meas_table !== 8'hF4) begin n_err++; $display("FAIL f4_table_hold: got %h, want f4", hif.meas_table); end
  endtask

  task automatic test_settle_zero();
    int busy_cnt = 0;
    int walk_err = 0;
    logic [7:0] exp_t;
    start_pulse0();
    sb_q.push_back(8'hFF);
    while (hif0.busy && busy_cnt < 200) begin
      if (dut_in0 !== 3'(busy_cnt)) walk_err++;
      busy_cnt++;
      @(negedge clk);
    end
    n_vec++; if (busy_cnt != 8) begin n_err++; $display("FAIL s0_busy_len: got %0d, want 8", busy_cnt); end
    n_vec++; if (walk_err != 0) begin n_err++; $display("FAIL s0_dut_in_walk: got %0d bad cycles, want 0", walk_err); end
    n_vec++; if (hif0.done !== 1'b1) begin n_err++; $display("FAIL s0_done: got %b, want 1", hif0.done); end
    exp_t = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
    n_vec++; if (hif0.meas_table !== exp_t) begin n_err++; $display("FAIL s0_table: got %h, want %h", hif0.meas_table, exp_t); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    bit ok;
    bit seen_done = 1'b0;
    logic [7:0] exp_t;
    start_pulse();
    for (int i = 0; i < 100 && dut_in !== 3'd3; i++) @(negedge clk);
    n_vec++; if (dut_in !== 3'd3) begin n_err++; $display("FAIL abort_reach_v3: got %0d, want 3", dut_in); end
    hif.abort = 1'b1;
    @(negedge clk); hif.abort = 1'b0;
    n_vec++; if ({hif.busy, hif.done, dut_in} !== 5'd0) begin n_err++; $display("FAIL abort_idle: got %b, want 00000", {hif.busy, hif.done, dut_in}); end
    n_vec++; if (hif.meas_table !== 8'hE0) begin n_err++; $display("FAIL abort_partial: got %h, want e0", hif.meas_table); end
    repeat (45) begin @(negedge clk); if (hif.done) seen_done = 1'b1; end
    n_vec++; if (seen_done) begin n_err++; $display("FAIL abort_no_done: got done pulse, want none"); end
    // Abort in the final SAMPLE must block both the capture and the DONE transition.
    start_pulse0();
    for (int i = 0; i < 100 && dut_in0 !== 3'd7; i++) @(negedge clk);
    hif0.abort = 1'b1;
    @(negedge clk); hif0.abort = 1'b0;
    n_vec++; if ({hif0.busy, hif0.done} !== 2'b00) begin n_err++; $display("FAIL abort_last_state: got %b, want 00", {hif0.busy, hif0.done}); end
    n_vec++; if (hif0.meas_table !== 8'hFE) begin n_err++; $display("FAIL abort_last_table: got %h, want fe", hif0.meas_table); end
    @(negedge clk);
    n_vec++; if (hif0.done !== 1'b0) begin n_err++; $display("FAIL abort_last_no_done: got %b, want 0", hif0.done); end
    start_pulse();
    sb_q.push_back(8'hF4);
    wait_done(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL abort_restart_done: got timeout, want done"); end
    exp_t = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
    n_vec++; if (hif.meas_table !== exp_t) begin n_err++; $display("FAIL abort_restart_table: got %h, want %h", hif.meas_table, exp_t); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] exp_t;
    sb_q.push_back(8'hF4);
    sb_q.push_back(8'hF4);
    @(negedge clk); hif.start = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_done(ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_done_%0d: got timeout, want done", k); end
      exp_t = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
      n_vec++; if (hif.meas_table !== exp_t) begin n_err++; $display("FAIL b2b_table_%0d: got %h, want %h", k, hif.meas_table, exp_t); end
      @(negedge clk);
      n_vec++; if ({hif.busy, hif.done, dut_in} !== 5'd0) begin n_err++; $display("FAIL b2b_gap_%0d: got %b, want 00000", k, {hif.busy, hif.done, dut_in}); end
      @(negedge clk);
      n_vec++; if (hif.busy !== 1'b1) begin n_err++; $display("FAIL b2b_restart_%0d: got busy %b, want 1", k, hif.busy); end
    end
    hif.start = 1'b0; hif.abort = 1'b1;
    @(negedge clk); hif.abort = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] exp_t;
    start_pulse();
    for (int i = 0; i < 100 && dut_in !== 3'd5; i++) @(negedge clk);
    n_vec++; if (dut_in !== 3'd5) begin n_err++; $display("FAIL rst_reach_v5: got %0d, want 5", dut_in); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if ({hif.busy, hif.done, dut_in, hif.meas_table} !== 13'd0) begin n_err++; $display("FAIL rst_async: got %h, want 0", {hif.busy, hif.done, dut_in, hif.meas_table}); end
    @(negedge clk); rst = 1'b0;
    start_pulse();
    sb_q.push_back(8'hF4);
    wait_done(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rst_restart_done: got timeout, want done"); end
    exp_t = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
    n_vec++; if (hif.meas_table !== exp_t) begin n_err++; $display("FAIL rst_restart_table: got %h, want %h", hif.meas_table, exp_t); end
    @(negedge clk);
  endtask

`ifdef TT_SWEEP_COMPARE_EN
  task automatic test_compare();
    bit ok;
    logic [7:0] exp_t;
    hif.expected = 8'hF5;
    start_pulse();
    sb_q.push_back(8'hF4);
    wait_done(ok);
    n_vec++; if (!ok || hif.mismatch !== 1'b1) begin n_err++; $display("FAIL cmp_mismatch_set: got %b, want 1", hif.mismatch); end
    exp_t = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
    n_vec++; if (hif.meas_table !== exp_t) begin n_err++; $display("FAIL cmp_table: got %h, want %h", hif.meas_table, exp_t); end
    repeat (2) @(negedge clk);
    n_vec++; if (hif.mismatch !== 1'b1) begin n_err++; $display("FAIL cmp_mismatch_hold: got %b, want 1", hif.mismatch); end
    hif.expected = 8'hF4;
    start_pulse();
    n_vec++; if (hif.mismatch !== 1'b0) begin n_err++; $display("FAIL cmp_mismatch_clear: got %b, want 0", hif.mismatch); end
    wait_done(ok);
    n_vec++; if (!ok || hif.mismatch !== 1'b0) begin n_err++; $display("FAIL cmp_mismatch_match: got %b, want 0", hif.mismatch); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_sweep_f4();
    test_settle_zero();
    test_abort();
    test_back_to_back();
    test_reset_mid();
`ifdef TT_SWEEP_COMPARE_EN
    test_compare();
`endif
    n_vec++; if (sb_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left, want 0", sb_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
